// File: rtl/fetch_pc_unit.sv
// Program counter and fetch control in front of a 1-cycle-latency instruction memory.
// Latency: pc is combinational; fetch_pc/fetch_valid describe the memory output one cycle after pc.
// Backpressure: stall with a valid instruction re-presents the held address so the memory output stays put.
module fetch_pc_unit #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int LAST_ADDR     = 32,
    parameter int RESET_PC      = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall,
    input  logic                     redirect_valid,
    input  logic [ADDRESS_WIDTH:0]   redirect_target,
    input  logic                     halt_req,
    output logic [ADDRESS_WIDTH:0]   pc,
    output logic [ADDRESS_WIDTH:0]   fetch_pc,
    output logic                     fetch_valid,
    output logic                     halted,
    output logic                     addr_error
);

    localparam int PW = ADDRESS_WIDTH + 1;
    localparam logic [PW-1:0] LAST  = PW'(LAST_ADDR);
    localparam logic [PW-1:0] START = PW'(RESET_PC);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t          state;
    logic [PW-1:0]   pc_q;
    logic            hold;

    // A stall only matters when there is a real instruction to hold.
    assign hold   = stall & fetch_valid;
    assign halted = (state == HALTED);
    assign pc     = (hold || state == DRAIN) ? fetch_pc : pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= START;
            fetch_pc    <= '0;
            fetch_valid <= 1'b0;
            state       <= RUN;
            addr_error  <= 1'b0;
        end else begin
            case (state)
                RUN, DRAIN: begin
                    if (halt_req) begin
                        state       <= HALTED;
                        fetch_valid <= 1'b0;
                    end else if (redirect_valid) begin
                        // The memory already sampled the old pc, so one squash bubble follows.
                        fetch_valid <= 1'b0;
                        if (redirect_target <= LAST) begin
                            pc_q  <= redirect_target;
                            state <= RUN;
                        end else begin
                            state      <= HALTED;
                            addr_error <= 1'b1;
                        end
                    end else if (hold) begin
                        state <= state;
                    end else if (state == RUN) begin
                        fetch_pc    <= pc_q;
                        fetch_valid <= 1'b1;
                        if (pc_q < LAST) begin
                            pc_q <= pc_q + PW'(1);
                        end else begin
                            state <= DRAIN;
                        end
                    end else begin
                        state       <= HALTED;
                        fetch_valid <= 1'b0;
                    end
                end
                HALTED: begin
                    fetch_valid <= 1'b0;
                end
                default: begin
                    state       <= HALTED;
                    fetch_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Randomized scoreboard bench for fetch_pc_unit against an address-stream reference model.
module tb_fetch_pc_unit;

    logic       clk;
    logic       rst;
    logic       stall;
    logic       redirect_valid;
    logic [5:0] redirect_target;
    logic       halt_req;
    logic [5:0] pc;
    logic [5:0] fetch_pc;
    logic       fetch_valid;
    logic       halted;
    logic       addr_error;

    fetch_pc_unit #(.ADDRESS_WIDTH(5), .LAST_ADDR(32), .RESET_PC(0)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .halt_req       (halt_req),
        .pc             (pc),
        .fetch_pc       (fetch_pc),
        .fetch_valid    (fetch_valid),
        .halted         (halted),
        .addr_error     (addr_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [5:0] pc;
        logic [5:0] fpc;
        logic       fv;
        logic       hl;
        logic       ae;
    } exp_t;

    exp_t exp_q[$];
    int total = 0;
    int bad   = 0;

    // Reference model: the address stream the unit should be producing.
    int  m_next;      // next address to send to memory
    int  m_out;       // address whose instruction sits on the memory output
    bit  m_ok;        // that instruction is in-path
    bit  m_stop;      // fetching has ended for good (until reset)
    bit  m_err;       // an out-of-range jump was seen
    bit  m_last;      // the final address has been issued; nothing more to fetch

    task automatic model_step();
        if (rst) begin
            m_next = 0; m_out = 0; m_ok = 0; m_stop = 0; m_err = 0; m_last = 0;
        end else if (m_stop) begin
            m_ok = 0;
        end else if (halt_req) begin
            m_stop = 1; m_ok = 0;
        end else if (redirect_valid) begin
            m_ok = 0;
            if (int'(redirect_target) > 32) begin
                m_stop = 1; m_err = 1;
            end else begin
                m_next = int'(redirect_target); m_last = 0;
            end
        end else if (stall && m_ok) begin
            m_ok = m_ok;
        end else if (m_last) begin
            m_stop = 1; m_ok = 0;
        end else begin
            m_out = m_next; m_ok = 1;
            if (m_next == 32) m_last = 1;
            else m_next = m_next + 1;
        end
    endtask

    task automatic drive(input logic r, input logic st, input logic rv,
                         input logic [5:0] rt, input logic h);
        exp_t e;
        @(posedge clk);
        #1;
        model_step();
        rst = r; stall = st; redirect_valid = rv; redirect_target = rt; halt_req = h;
        if ((m_last && !m_stop) || (st && m_ok)) e.pc = 6'(m_out);
        else e.pc = 6'(m_next);
        e.fpc = 6'(m_out);
        e.fv  = m_ok;
        e.hl  = m_stop;
        e.ae  = m_err;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 6'd0, 0);
    endtask

    task automatic chk(input string name, input logic [5:0] act, input logic [5:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pc", pc, e.pc);
                chk("fetch_valid", 6'(fetch_valid), 6'(e.fv));
                chk("halted", 6'(halted), 6'(e.hl));
                chk("addr_error", 6'(addr_error), 6'(e.ae));
                if (e.fv) chk("fetch_pc", fetch_pc, e.fpc);
                else if (e.ae || !e.hl) chk("fetch_pc_idle", fetch_pc, e.fpc);
            end
        end
    end

    initial begin : stim
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0; halt_req = 1'b0;
        // Free run, then stall while an instruction is held.
        drive(0, 0, 0, 6'd0, 0);
        idle(6);
        drive(0, 1, 0, 6'd0, 0);
        drive(0, 1, 0, 6'd0, 0);
        drive(0, 1, 0, 6'd0, 0);
        idle(3);
        // Redirect to 20 mid-stream, and redirect during a stall.
        drive(0, 0, 1, 6'd20, 0);
        idle(3);
        drive(0, 1, 1, 6'd10, 0);
        idle(2);
        // Run off the end of memory: drain then halt, redirect ignored while halted.
        drive(0, 0, 1, 6'd31, 0);
        idle(4);
        drive(0, 0, 1, 6'd5, 0);
        idle(1);
        // Illegal target, then reset recovery.
        drive(1, 0, 0, 6'd0, 0);
        idle(3);
        drive(0, 0, 1, 6'd40, 0);
        idle(2);
        drive(1, 0, 0, 6'd0, 0);
        idle(3);
        // Halt beats an illegal redirect and a stall in the same cycle.
        drive(0, 1, 1, 6'd40, 1);
        idle(2);
        // Reset issued while stalled.
        drive(1, 0, 0, 6'd0, 0);
        idle(3);
        drive(0, 1, 0, 6'd0, 0);
        drive(1, 1, 0, 6'd0, 0);
        drive(0, 1, 0, 6'd0, 0);
        idle(2);
        // Stall held in the DRAIN state, then a legal redirect out of it.
        drive(0, 0, 1, 6'd31, 0);
        idle(2);
        drive(0, 1, 0, 6'd0, 0);
        drive(0, 1, 0, 6'd0, 0);
        drive(0, 0, 1, 6'd2, 0);
        idle(3);
        for (int i = 0; i < 3000; i++) begin
            logic       r, st, rv, h;
            logic [5:0] rt;
            r  = ($urandom_range(0, 39) == 0);
            st = ($urandom_range(0, 9) < 3);
            rv = ($urandom_range(0, 11) == 0);
            h  = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 6) == 0) rt = 6'($urandom_range(33, 63));
            else rt = 6'($urandom_range(0, 32));
            drive(r, st, rv, rt, h);
        end
        idle(1);
        repeat (3) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Program-counter and fetch-control stage directly upstream of the instruction memory.
- Generates the read address `pc` each cycle and tracks which address the memory's registered output corresponds to (1-cycle read latency).
- Qualifies that output with `fetch_valid` and applies stall, redirect (branch/jump) and halt control from the downstream decode/execute logic.

Parameters:
- ADDRESS_WIDTH, 5, PC width is ADDRESS_WIDTH+1 bits, matching the memory address port.
- LAST_ADDR, 32, highest valid instruction address; the memory holds entries 0..LAST_ADDR.
- RESET_PC, 0, first address fetched after reset.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- stall  input  1  downstream not accepting the current instruction; hold it.
- redirect_valid  input  1  taken branch/jump this cycle.
- redirect_target  input  ADDRESS_WIDTH+1  new fetch address when redirect_valid=1.
- halt_req  input  1  downstream decoded a halt; stop fetching.
- pc  output  ADDRESS_WIDTH+1  read address to instruction memory, sampled by memory on the next edge.
- fetch_pc  output  ADDRESS_WIDTH+1  address of the instruction currently on the memory output.
- fetch_valid  output  1  memory output is a valid, in-path instruction.
- halted  output  1  unit in HALTED state.
- addr_error  output  1  sticky: a redirect targeted an address > LAST_ADDR.

Behaviour:
- Registers: pc_q, fetch_pc, fetch_valid, state {RUN, DRAIN, HALTED}, addr_error.
- Reset (rst=1 at an edge):
  - pc_q=RESET_PC, fetch_pc=0, fetch_valid=0, state=RUN, halted=0, addr_error=0.
  - Overrides every other input, including mid-redirect, mid-stall and HALTED.
- pc output (combinational):
  - Equals fetch_pc when (stall=1 and fetch_valid=1) or state=DRAIN.
  - Otherwise equals pc_q.
  - This makes the memory re-read the held address, so its output stays stable.
- Priority per edge, outside reset: halt_req > redirect_valid > effective stall > advance.
  - Effective stall = stall & fetch_valid. A stall during a bubble is ignored and the pipeline advances.
- RUN:
  - halt_req: state=HALTED, fetch_valid=0, pc_q holds.
  - redirect, target<=LAST_ADDR: pc_q=target, fetch_valid=0. One squash bubble, because the memory sampled the old pc at this edge. The target's instruction is valid two cycles after the redirect cycle, with fetch_pc=target.
  - redirect, target>LAST_ADDR: state=HALTED, addr_error=1, fetch_valid=0.
  - Effective stall: all registers hold.
  - Advance: fetch_pc=pc_q, fetch_valid=1.
    - If pc_q<LAST_ADDR: pc_q=pc_q+1.
    - If pc_q==LAST_ADDR: pc_q holds, state=DRAIN. No wrap-around to 0 ever occurs.
- DRAIN (last instruction on output, fetch_valid=1):
  - halt_req: HALTED, fetch_valid=0.
  - Redirect: handled exactly as in RUN; a legal target returns to RUN with one bubble.
  - Effective stall: hold.
  - Otherwise: state=HALTED, fetch_valid=0.
- HALTED:
  - fetch_valid=0, halted=1; pc and fetch_pc hold.
  - stall, redirect_valid and halt_req are all ignored; only rst exits.
- halted is combinational from state. fetch_valid, fetch_pc and addr_error are register outputs.
- Simultaneous halt_req and redirect_valid: halt wins; addr_error is not set even if the target is illegal.
- Simultaneous redirect_valid and stall: redirect wins; the stalled instruction is discarded.

Test Plan:
- Reset, then 4 cycles free-running → pc 0,1,2,3,4 on successive cycles. fetch_valid=0 in cycle 0, then 1. fetch_pc 0,1,2,3 in cycles 1–4.
- stall=1 for 3 cycles while fetch_pc=5 → pc=5, fetch_pc=5, fetch_valid=1 held all 3 cycles. After release: fetch_pc=6 next cycle, then 7.
- redirect_valid=1, target=20 while fetch_pc=3 → one cycle fetch_valid=0, then fetch_valid=1 with fetch_pc=20, then 21.
- redirect to 31, no further control → fetch_pc 31, 32 valid. pc holds at 32 in DRAIN. Next cycle halted=1, fetch_valid=0, and redirect_valid to 0 has no effect.
- redirect target=40 (>32) → halted=1 and addr_error=1 next cycle, fetch_valid=0. Then rst=1 for one cycle → all outputs return to reset values and fetch restarts from 0.
- Same cycle halt_req=1, redirect_valid=1, target=40, stall=1 → HALTED, addr_error=0, fetch_valid=0. Mid-stall rst → fetch_valid=0, pc=0 the next cycle.
